// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - I2S stereo transmitter gated by PLL lock; I2S_UNDERRUN_HOLD_EN repeats the last frame on underrun
module audio_i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int SLOT_W    = 32,
    parameter int BCLK_DIV  = 4,
    parameter int LOCK_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              underrun_clr,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_dout,
    output logic              running,
    output logic              underrun
);
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int LOCK_W     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_RIGHT = BIT_W'(SLOT_W);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]            state;
    logic [LOCK_W-1:0]     lock_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  buf_full;
    logic [DATA_W-1:0]     buf_left;
    logic [DATA_W-1:0]     buf_right;
    logic [FRAME_BITS-1:0] shift_reg;

    logic                  fall_tick;
    logic                  frame_wrap;
    logic [DIV_W-1:0]      div_next;
    logic [BIT_W-1:0]      bit_next;
    logic [SLOT_W-1:0]     buf_left_pad;
    logic [SLOT_W-1:0]     buf_right_pad;
    logic [FRAME_BITS-1:0] load_frame;

`ifdef I2S_UNDERRUN_HOLD_EN
    logic [FRAME_BITS-1:0] frame_reg;
`endif

    assign running = (state == ST_RUN);
    assign s_ready = (state == ST_RUN) && !buf_full;

    always_comb begin
        fall_tick     = (state == ST_RUN) && (div_cnt == DIV_LAST);
        frame_wrap    = fall_tick && (bit_cnt == BIT_LAST);
        div_next      = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        bit_next      = bit_cnt;
        if (fall_tick) begin
            bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        // Samples are left-justified in their slot, zero padded below the LSB.
        buf_left_pad  = SLOT_W'(buf_left) << (SLOT_W - DATA_W);
        buf_right_pad = SLOT_W'(buf_right) << (SLOT_W - DATA_W);
        if (buf_full) begin
            load_frame = {buf_left_pad, buf_right_pad};
        end else begin
`ifdef I2S_UNDERRUN_HOLD_EN
            load_frame = frame_reg;
`else
            load_frame = '0;
`endif
        end
    end

`ifdef I2S_UNDERRUN_HOLD_EN
    // Outside RUN the frame register stays clear, so the entry frame is silence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_reg <= '0;
        end else if (!pll_lock || state != ST_RUN) begin
            frame_reg <= '0;
        end else if (frame_wrap) begin
            frame_reg <= load_frame;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lock_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_dout  <= 1'b0;
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
            shift_reg <= '0;
            underrun  <= 1'b0;
        end else begin
            if (underrun_clr) begin
                underrun <= 1'b0;
            end
            if (!pll_lock) begin
                state     <= ST_IDLE;
                lock_cnt  <= '0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                i2s_bclk  <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_dout  <= 1'b0;
                buf_full  <= 1'b0;
                buf_left  <= '0;
                buf_right <= '0;
                shift_reg <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_WAIT;
                        lock_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (lock_cnt == LOCK_LAST) begin
                            state     <= ST_RUN;
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        div_cnt  <= div_next;
                        bit_cnt  <= bit_next;
                        i2s_bclk <= (div_next >= DIV_HALF);
                        i2s_lrck <= (bit_next >= BIT_RIGHT);
                        // dout lags the shift register by one bit: the I2S one-BCLK delay.
                        if (fall_tick) begin
                            i2s_dout <= shift_reg[FRAME_BITS-1];
                            if (frame_wrap) begin
                                shift_reg <= load_frame;
                                buf_full  <= 1'b0;
                                if (!buf_full) begin
                                    underrun <= 1'b1;
                                end
                            end else begin
                                shift_reg <= shift_reg << 1;
                            end
                        end
                        if (s_valid && !buf_full) begin
                            buf_full  <= 1'b1;
                            buf_left  <= s_left;
                            buf_right <= s_right;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - self-checking bench for audio_i2s_tx (honours I2S_UNDERRUN_HOLD_EN)
module tb_audio_i2s_tx;
    localparam int DATA_W    = 16;
    localparam int SLOT_W    = 32;
    localparam int BCLK_DIV  = 4;
    localparam int LOCK_WAIT = 8;
    localparam int FRAME_CLK = 2 * SLOT_W * BCLK_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_lock = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_left = '0;
    logic [DATA_W-1:0] s_right = '0;
    logic              underrun_clr = 1'b0;
    logic              s_ready;
    logic              i2s_bclk;
    logic              i2s_lrck;
    logic              i2s_dout;
    logic              running;
    logic              underrun;

    int n_pass = 0;
    int n_total = 0;

    int clk_n = 0;
    int entry_n = 0;
    logic [31:0] pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] hold_frame = '0;
    logic [31:0] got;
    logic [31:0] exp_f;
    logic [31:0] last_got = '0;
    logic [31:0] idle_f;
    int acc_cnt = 0;
    int acc_time = 0;
    int a5_cnt = 0;
    int bp_cnt = 0;
    bit in_run = 1'b0;
    logic prev_bclk = 1'b0;
    logic last_lrck = 1'b1;
    int k = 0;
    logic [30:0] word = '0;
    logic [30:0] lw = '0;

    audio_i2s_tx #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .LOCK_WAIT(LOCK_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .underrun_clr(underrun_clr),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dout(i2s_dout),
        .running(running), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_n <= clk_n + 1;

    // Frame model and serial monitor, evaluated mid-cycle before the next active edge.
    always @(negedge clk) begin
        if (!running) begin
            in_run = 1'b0;
            pend.delete();
            exp_q.delete();
            k = 0;
            last_lrck = 1'b1;
            prev_bclk = 1'b0;
            hold_frame = '0;
        end else begin
            if (!in_run) begin
                in_run = 1'b1;
                entry_n = clk_n;
                exp_q.push_back(32'h0);
            end
            if (!prev_bclk && i2s_bclk) begin
                if (i2s_lrck != last_lrck) k = 0;
                else k++;
                last_lrck = i2s_lrck;
                if (k >= 1 && k <= 31) word = {word[29:0], i2s_dout};
                if (k == 31) begin
                    if (!i2s_lrck) begin
                        lw = word;
                    end else begin
                        got = {lw[30:15], word[30:15]};
                        n_total++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL frame_unexpected got=%h expected=none", got);
                        end else begin
                            exp_f = exp_q.pop_front();
                            if (got !== exp_f || lw[14:0] !== 15'd0 || word[14:0] !== 15'd0)
                                $display("FAIL frame_data got=%h pad=%h/%h expected=%h pad=0",
                                         got, lw[14:0], word[14:0], exp_f);
                            else
                                n_pass++;
                        end
                        if (got == 32'hA5C38001) a5_cnt++;
                        if (got[31:24] == 8'h10 && got != last_got) bp_cnt++;
                        last_got = got;
                    end
                end
            end
            prev_bclk = i2s_bclk;
            if (((clk_n - entry_n) % FRAME_CLK) == FRAME_CLK - 1) begin
`ifdef I2S_UNDERRUN_HOLD_EN
                idle_f = hold_frame;
`else
                idle_f = 32'h0;
`endif
                if (pend.size() > 0) begin
                    idle_f = pend.pop_front();
                    hold_frame = idle_f;
                end
                exp_q.push_back(idle_f);
            end
            if (s_valid && s_ready) begin
                pend.push_back({s_left, s_right});
                acc_cnt++;
                acc_time = clk_n;
            end
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (((clk_n - entry_n) % FRAME_CLK) != p && n < 2 * FRAME_CLK);
        if (n >= 2 * FRAME_CLK) begin
            n_total++;
            $display("FAIL wait_phase timeout phase=%0d", p);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        int a0 = acc_cnt;
        int n = 0;
        s_left = l; s_right = r; s_valid = 1'b1;
        while (acc_cnt == a0 && n < 2 * FRAME_CLK) begin
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        n_total++;
        if (acc_cnt == a0) $display("FAIL accept_timeout got=no_accept expected=accept");
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({i2s_bclk, i2s_lrck, i2s_dout, s_ready, running, underrun} !== 6'b0)
            $display("FAIL reset_outputs got=%b expected=000000",
                     {i2s_bclk, i2s_lrck, i2s_dout, s_ready, running, underrun});
        else n_pass++;
    endtask

    task automatic test_lock_start;
        int n = 0;
        int quiet_bad = 0;
        int bclk_bad = 0;
        int r1 = -1;
        int r2 = -1;
        int high = 0;
        logic prev = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        pll_lock = 1'b1;
        while (!running && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (!running && (i2s_bclk || i2s_lrck)) quiet_bad++;
        end
        n_total++;
        if (n !== 9) $display("FAIL lock_start_latency got=%0d expected=9", n);
        else n_pass++;
        n_total++;
        if (quiet_bad != 0) $display("FAIL no_bclk_before_run got=%0d expected=0", quiet_bad);
        else n_pass++;
        n_total++;
        if ({i2s_bclk, i2s_lrck, i2s_dout} !== 3'b000)
            $display("FAIL run_entry_state got=%b expected=000", {i2s_bclk, i2s_lrck, i2s_dout});
        else n_pass++;
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL ready_in_run got=%b expected=1", s_ready);
        else n_pass++;
        for (int c = 0; c <= 400; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (i2s_bclk !== ((c % BCLK_DIV) >= BCLK_DIV / 2)) bclk_bad++;
            if (i2s_lrck && r1 < 0) r1 = c;
            else if (r1 >= 0 && r2 < 0 && i2s_lrck && !prev) r2 = c;
            if (i2s_lrck && r1 >= 0 && r2 < 0) high++;
            prev = i2s_lrck;
        end
        n_total++;
        if (bclk_bad != 0) $display("FAIL bclk_period4 got=%0d_bad_cycles expected=0", bclk_bad);
        else n_pass++;
        n_total++;
        if (r1 != 128) $display("FAIL lrck_first_rise got=%0d expected=128", r1);
        else n_pass++;
        n_total++;
        if (r2 - r1 != FRAME_CLK || high != FRAME_CLK / 2)
            $display("FAIL lrck_period_duty got=%0d/%0d expected=256/128", r2 - r1, high);
        else n_pass++;
    endtask

    task automatic test_serial;
        int a5_0;
        wait_phase(10);
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL serial_clr got=%b expected=0", underrun);
        else n_pass++;
        a5_0 = a5_cnt;
        send_frame(16'hA5C3, 16'h8001);
        wait_phase(10);
        n_total++;
        if (underrun !== 1'b0) $display("FAIL no_underrun_with_data got=%b expected=0", underrun);
        else n_pass++;
        wait_phase(10);
        n_total++;
        if (underrun !== 1'b1) $display("FAIL underrun_second_start got=%b expected=1", underrun);
        else n_pass++;
        wait_phase(10);
        n_total++;
`ifdef I2S_UNDERRUN_HOLD_EN
        if (a5_cnt - a5_0 != 2) $display("FAIL hold_repeat got=%0d expected=2", a5_cnt - a5_0);
        else n_pass++;
`else
        if (a5_cnt - a5_0 != 1) $display("FAIL serial_once got=%0d expected=1", a5_cnt - a5_0);
        else n_pass++;
`endif
    endtask

    task automatic test_underrun;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL underrun_clr got=%b expected=0", underrun);
        else n_pass++;
        wait_phase(FRAME_CLK - 1);
        n_total++;
        if (underrun !== 1'b0) $display("FAIL underrun_stays_clear got=%b expected=0", underrun);
        else n_pass++;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        n_total++;
        if (underrun !== 1'b1) $display("FAIL set_wins_over_clr got=%b expected=1", underrun);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int i = 0;
        int n = 0;
        int a_last;
        int bad = 0;
        int t_prev = 0;
        wait_phase(10);
        bp_cnt = 0;
        a_last = acc_cnt;
        s_left = 16'h1000; s_right = 16'h2000; s_valid = 1'b1;
        while (i < 10 && n < 12 * FRAME_CLK) begin
            @(posedge clk); #1;
            n++;
            if (acc_cnt != a_last) begin
                a_last = acc_cnt;
                if (i >= 2 && (acc_time - t_prev) != FRAME_CLK) bad++;
                t_prev = acc_time;
                i++;
                s_left = 16'h1000 + 16'(i);
                s_right = 16'h2000 + 16'(i);
            end
        end
        s_valid = 1'b0;
        n_total++;
        if (i != 10 || bad != 0) $display("FAIL bp_accept_rate got=%0d_accepts_%0d_bad_gaps expected=10_0", i, bad);
        else n_pass++;
        repeat (3) wait_phase(10);
        n_total++;
        if (bp_cnt != 10 || pend.size() != 0)
            $display("FAIL bp_frames_out got=%0d pend=%0d expected=10 pend=0", bp_cnt, pend.size());
        else n_pass++;
    endtask

    task automatic test_lock_loss;
        int n = 0;
        int r1 = -1;
        n_total++;
        if (underrun !== 1'b1) $display("FAIL underrun_before_loss got=%b expected=1", underrun);
        else n_pass++;
        wait_phase(10);
        send_frame(16'hFFFF, 16'hFFFF);
        wait_phase(10);
        wait_phase(150);
        n_total++;
        if ({i2s_bclk, i2s_lrck, i2s_dout, s_ready, running} !== 5'b11111)
            $display("FAIL pre_loss_state got=%b expected=11111",
                     {i2s_bclk, i2s_lrck, i2s_dout, s_ready, running});
        else n_pass++;
        pll_lock = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({i2s_bclk, i2s_lrck, i2s_dout, s_ready, running} !== 5'b00000)
            $display("FAIL lock_loss_outputs got=%b expected=00000",
                     {i2s_bclk, i2s_lrck, i2s_dout, s_ready, running});
        else n_pass++;
        n_total++;
        if (underrun !== 1'b1) $display("FAIL underrun_kept got=%b expected=1", underrun);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        pll_lock = 1'b1;
        while (!running && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n !== 9 || i2s_lrck !== 1'b0 || i2s_bclk !== 1'b0)
            $display("FAIL relock got=%0d_lrck%b_bclk%b expected=9_lrck0_bclk0", n, i2s_lrck, i2s_bclk);
        else n_pass++;
        for (int c = 0; c <= 130; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (i2s_lrck && r1 < 0) r1 = c;
        end
        n_total++;
        if (r1 != 128) $display("FAIL relock_lrck_rise got=%0d expected=128", r1);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        wait_phase(10);
        wait_phase(150);
        n_total++;
        if ({i2s_bclk, i2s_lrck, running, underrun} !== 4'b1111)
            $display("FAIL pre_reset_state got=%b expected=1111", {i2s_bclk, i2s_lrck, running, underrun});
        else n_pass++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({i2s_bclk, i2s_lrck, i2s_dout, s_ready, running, underrun} !== 6'b0)
            $display("FAIL async_reset got=%b expected=000000",
                     {i2s_bclk, i2s_lrck, i2s_dout, s_ready, running, underrun});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_start();
        test_serial();
        test_underrun();
        test_back_to_back();
        test_lock_loss();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Downstream consumer of the audio PLL. Runs on the PLL's 12.288 MHz MCLK output and uses its lock flag as a start gate.
- Derives I2S BCLK/LRCK (default 256·fs, fs = 48 kHz) and serialises stereo PCM frames to the codec DAC.
- Upstream audio pipeline delivers frames through a valid/ready handshake into a one-frame holding buffer.

Parameters:
- DATA_W, 16: PCM sample width per channel. Range 8..SLOT_W.
- SLOT_W, 32: BCLK periods per channel slot. Frame = 2·SLOT_W BCLK.
- BCLK_DIV, 4: MCLK cycles per BCLK. Even, ≥2.
- LOCK_WAIT, 1024: consecutive clk cycles pll_lock must be high before output starts.

Ports:
- clk  in  1  MCLK from PLL clkout0.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL lock, already synchronous to clk.
- s_valid  in  1  frame valid.
- s_ready  out  1  frame accept.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- underrun_clr  in  1  clears the underrun flag.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left.
- i2s_dout  out  1  serial data.
- running  out  1  high in RUN.
- underrun  out  1  sticky underrun flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, holding buffer empty, shift/frame registers 0.
- FSM:
  - IDLE: pll_lock=1 → WAIT with lock counter cleared.
  - WAIT: counts cycles while pll_lock=1. Counter reaching LOCK_WAIT-1 → RUN next cycle.
  - RUN: running=1.
  - pll_lock=0 in any state → IDLE next cycle. Counters, buffer and outputs return to reset values; underrun keeps its value.
- Clock divider (RUN only):
  - div_cnt runs 0..BCLK_DIV-1 and wraps.
  - i2s_bclk is registered: 0 while div_cnt < BCLK_DIV/2, else 1.
  - Fall tick = div_cnt==BCLK_DIV-1. All data and LRCK changes happen on the fall tick, so they update together with BCLK going low.
- Bit counter:
  - bit_cnt runs 0..2·SLOT_W-1 and advances on each fall tick.
  - i2s_lrck = (bit_cnt ≥ SLOT_W).
- Serial format: standard I2S.
  - Each slot's stream is the sample MSB-first, zero-padded to SLOT_W bits.
  - The stream is delayed one BCLK relative to LRCK: bit at slot position k=0 is the last stream bit of the previous slot. MSB appears at k=1.
  - The right slot's last bit spills into the next frame's left k=0.
- Handshake:
  - s_ready = RUN && buffer empty.
  - Transfer when s_valid && s_ready: {s_left,s_right} latched, buffer full.
  - Upstream must hold data stable while s_valid && !s_ready.
- Frame load at every frame start (fall tick with bit_cnt wrap to 0, and the RUN entry cycle):
  - Buffer full: copy to frame register, buffer empty.
  - Buffer empty: load zeros and set underrun=1. The load at RUN entry never sets underrun.
  - Accept and load cannot coincide, because s_ready=0 while the buffer is full.
- underrun_clr and a new underrun in the same cycle: set wins.
- Latency: first RUN cycle has bit_cnt=0, lrck=0, bclk=0. A frame accepted before a frame start appears starting at the next frame start. Its MSB is on dout from the fall tick ending bit 0 of that frame.
- Frame period = 2·SLOT_W·BCLK_DIV clk (256 by default).

Optional Feature:
- Macro I2S_UNDERRUN_HOLD_EN.
- Defined: on underrun the frame register keeps its previous contents, so the last frame repeats. underrun is still set.
- Undefined: zeros are loaded as described above.
- The first-frame load after RUN entry is zero in both cases.

Test Plan:
- Bench parameters: DATA_W=16, SLOT_W=32, BCLK_DIV=4, LOCK_WAIT=8.
- Lock start: pll_lock held high → running rises 9 cycles after pll_lock is first seen; bclk period 4 clk; lrck period 256 clk, 50% duty; no BCLK activity before running.
- Serial data: send one frame left=16'hA5C3, right=16'h8001 → dout on left k=1..16 = 1010010111000011 then 16 zeros; right k=1..16 = 1000000000000001; following frames zero.
- Underrun: no frame supplied after the first → underrun=1 at the second frame start; pulse underrun_clr → 0; a simultaneous underrun and clr leaves it 1.
- Backpressure: s_valid held high with incrementing data → exactly one frame accepted per 256 clk; no frame lost or duplicated over 10 frames.
- Lock loss: drop pll_lock mid-frame → next cycle bclk, lrck, dout, s_ready, running are 0; re-lock → restarts from bit_cnt=0 after LOCK_WAIT.
- Async reset: assert rst mid-frame between clock edges → outputs 0 immediately, underrun=0.
- With I2S_UNDERRUN_HOLD_EN: underrun → previous frame A5C3/8001 repeats.
